// File: rtl/elevator_pkg.sv
// Shared constants and state encoding for the single-car elevator.
// Status codes double as the FSM encoding seen by the request buffer.
package elevator_pkg;

  localparam int NUM_FLOORS = 8;
  localparam int FLOOR_W    = 3;

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_MOVE_UP    = 4'd1;
  localparam logic [3:0] ST_MOVE_DOWN  = 4'd2;
  localparam logic [3:0] ST_STOP       = 4'd3;
  localparam logic [3:0] ST_DOOR_OPEN  = 4'd7;
  localparam logic [3:0] ST_DOOR_CLOSE = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE       = ST_IDLE,
    S_MOVE_UP    = ST_MOVE_UP,
    S_MOVE_DOWN  = ST_MOVE_DOWN,
    S_STOP       = ST_STOP,
    S_DOOR_OPEN  = ST_DOOR_OPEN,
    S_DOOR_CLOSE = ST_DOOR_CLOSE
  } state_e;

endpackage

// File: rtl/elevator_req_scan.sv
// Request scan: pending work above/below/at the car floor and
// collective-scan stop decisions for each sweep direction.
module elevator_req_scan
  import elevator_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] upcall_i,
  input  logic [NUM_FLOORS-1:0] downcall_i,
  input  logic [NUM_FLOORS-1:0] floor_btn_i,
  input  logic [FLOOR_W-1:0]    floor_i,
  output logic                  above_o,
  output logic                  below_o,
  output logic                  here_o,
  output logic                  stop_up_o,
  output logic                  stop_down_o
);

  logic [NUM_FLOORS-1:0] req;

  assign req = upcall_i | downcall_i | floor_btn_i;

  // OR-reduce requests strictly above and strictly below the car
  always_comb begin
    above_o = 1'b0;
    below_o = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(floor_i)) above_o = above_o | req[i];
      if (i < int'(floor_i)) below_o = below_o | req[i];
    end
  end

  assign here_o = req[floor_i];

  // Opposite-direction hall calls only served at the end of a sweep
  assign stop_up_o = floor_btn_i[floor_i]
                   | upcall_i[floor_i]
                   | (downcall_i[floor_i] & ~above_o);

  assign stop_down_o = floor_btn_i[floor_i]
                     | downcall_i[floor_i]
                     | (upcall_i[floor_i] & ~below_o);

endmodule

// File: rtl/elevator_scheduler.sv
// Collective-scan car motion and door controller.
// ELEVATOR_DOOR_HOLD_EN adds the door_hold input.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int FLOOR_TICKS = 100,
  parameter int DOOR_TICKS  = 200,
  parameter int CLOSE_TICKS = 50,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] upcall,
  input  logic [NUM_FLOORS-1:0] downcall,
  input  logic [NUM_FLOORS-1:0] floor_btn,
`ifdef ELEVATOR_DOOR_HOLD_EN
  input  logic                  door_hold,
`endif
  output logic [FLOOR_W-1:0]    floor,
  output logic [3:0]            status,
  output logic                  dir_up,
  output logic                  door_open
);

  localparam logic [CNT_W-1:0] FL_END = CNT_W'(FLOOR_TICKS - 1);
  localparam logic [CNT_W-1:0] DO_END = CNT_W'(DOOR_TICKS - 1);
  localparam logic [CNT_W-1:0] CL_END = CNT_W'(CLOSE_TICKS - 1);

  state_e             state_q, state_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               door_q, door_d;

  logic above, below, here, stop_up, stop_down;
  logic hold;

`ifdef ELEVATOR_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  elevator_req_scan u_scan (
    .upcall_i    (upcall),
    .downcall_i  (downcall),
    .floor_btn_i (floor_btn),
    .floor_i     (floor_q),
    .above_o     (above),
    .below_o     (below),
    .here_o      (here),
    .stop_up_o   (stop_up),
    .stop_down_o (stop_down)
  );

  // Next-state, counter, floor and direction decisions
  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (here) begin
          state_d = S_DOOR_OPEN;
        end else if (above && (dir_q || !below)) begin
          state_d = S_MOVE_UP;
          dir_d   = 1'b1;
        end else if (below) begin
          state_d = S_MOVE_DOWN;
          dir_d   = 1'b0;
        end
      end
      S_MOVE_UP: begin
        if (cnt_q == FL_END) begin
          floor_d = floor_q + 1'b1;
          cnt_d   = '0;
          state_d = S_STOP;
        end
      end
      S_MOVE_DOWN: begin
        if (cnt_q == FL_END) begin
          floor_d = floor_q - 1'b1;
          cnt_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        cnt_d = '0;
        if (dir_q ? stop_up : stop_down) begin
          state_d = S_DOOR_OPEN;
        end else if (dir_q && above) begin
          state_d = S_MOVE_UP;
        end else if (!dir_q && below) begin
          state_d = S_MOVE_DOWN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DOOR_OPEN: begin
        if (hold) begin
          cnt_d = '0;
        end else if (cnt_q == DO_END) begin
          cnt_d   = '0;
          state_d = S_DOOR_CLOSE;
        end
      end
      S_DOOR_CLOSE: begin
        if (here || hold) begin
          cnt_d   = '0;
          state_d = S_DOOR_OPEN;
        end else if (cnt_q == CL_END) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    door_d = (state_d == S_DOOR_OPEN) ||
             (state_d == S_DOOR_CLOSE);
  end

  // State and output registers, reset returns car to floor 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      floor_q <= '0;
      dir_q   <= 1'b1;
      cnt_q   <= '0;
      door_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      door_q  <= door_d;
    end
  end

  assign floor     = floor_q;
  assign status    = state_q;
  assign dir_up    = dir_q;
  assign door_open = door_q;

endmodule
